// File: rtl/render_pkg.sv
// Shared rendering types and constants for the hit/shade/write stage.
//   rgb444_t       : 12-bit colour, 4 bits per channel {R,G,B}
//   MISS_BLOCK     : block index reported by intersection on a miss
//   NUM_BLOCKS     : number of real blocks (palette entries)
//   BG_COLOUR      : colour used for misses, negative distances, bad floats
//   PALETTE        : per-block base colour
//   palette_lookup : block index -> colour, indices >= NUM_BLOCKS give BG_COLOUR
package render_pkg;

  typedef logic [11:0] rgb444_t;

  localparam logic [3:0] MISS_BLOCK = 4'd15;
  localparam int unsigned NUM_BLOCKS = 12;
  localparam rgb444_t BG_COLOUR = 12'h000;

  localparam rgb444_t PALETTE [NUM_BLOCKS] = '{
    12'hF00, 12'h0F0, 12'h00F, 12'hFF0,
    12'h0FF, 12'hF0F, 12'hFFF, 12'h888,
    12'hF80, 12'h8F0, 12'h08F, 12'h444
  };

  function automatic rgb444_t palette_lookup(input logic [3:0] blk);
    if (blk < 4'(NUM_BLOCKS)) return PALETTE[blk];
    else return BG_COLOUR;
  endfunction

endpackage

// File: rtl/result_fifo.sv
// First-word-fall-through result FIFO with registered storage.
//   clk, rst : clock, asynchronous active-high reset
//   push/din : write request and data; ignored when full unless a pop
//              happens in the same cycle
//   pop      : read request; ignored when empty
//   dout     : head entry, forced to zero while empty
//   full     : DEPTH entries held
//   empty    : no entries held
module result_fifo #(
  parameter int unsigned WIDTH = 29,
  parameter int unsigned DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  // Storage is not reset; the zero-gate on dout keeps the output defined.
  assign dout = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + (AW)'(1);
      if (do_pop)  rd_ptr <= rd_ptr + (AW)'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/hit_shade_writer.sv
// Colours per-pixel intersection results and writes them to the frame buffer.
// Build option: define DEPTH_SHADE_EN to darken colours by hit distance.
//   clk_in, rst_in : clock, asynchronous active-high reset
//   x_in, y_in     : pixel coordinates
//   best_block_in  : hit block index (>= 12 is a miss)
//   best_t_in      : IEEE-754 single hit distance
//   valid_in       : qualifies the inputs for one cycle
//   fb_ready       : frame buffer accepts the write this cycle
//   fb_addr/fb_data/fb_we : frame-buffer write port (y*H_RES+x, RGB444)
//   frame_done     : one-cycle pulse after the last pixel is accepted
//   overflow       : sticky, a result was dropped on a full FIFO
module hit_shade_writer
  import render_pkg::*;
#(
  parameter int unsigned H_RES      = 320,
  parameter int unsigned V_RES      = 240,
  parameter int unsigned FIFO_DEPTH = 16,
  parameter int          SHADE_BIAS = 0
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic [10:0] x_in,
  input  logic [9:0]  y_in,
  input  logic [3:0]  best_block_in,
  input  logic [31:0] best_t_in,
  input  logic        valid_in,
  input  logic        fb_ready,
  output logic [16:0] fb_addr,
  output logic [11:0] fb_data,
  output logic        fb_we,
  output logic        frame_done,
  output logic        overflow
);

  localparam logic [16:0] LAST_ADDR = 17'(H_RES * V_RES - 1);

  // S1: range filter and palette lookup
  logic        s1_valid;
  logic [10:0] s1_x;
  logic [9:0]  s1_y;
  rgb444_t     s1_colour;
  logic        s1_miss;
  logic        s1_neg;
  logic [7:0]  s1_exp;

  // S2: shading and address
  logic        s2_valid;
  logic [16:0] s2_addr;
  rgb444_t     s2_colour;

  logic [1:0]  shift;
  logic        bg;
  rgb444_t     shaded;
  logic [16:0] addr;
  logic        in_range;

  logic        fifo_full;
  logic        fifo_empty;
  logic        accept;

  logic unused_bits;
  assign unused_bits = &{1'b0, best_t_in[22:0]};

  assign in_range = (x_in < 11'(H_RES)) && (y_in < 10'(V_RES));

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      s1_valid  <= 1'b0;
      s1_x      <= '0;
      s1_y      <= '0;
      s1_colour <= BG_COLOUR;
      s1_miss   <= 1'b0;
      s1_neg    <= 1'b0;
      s1_exp    <= '0;
    end else begin
      s1_valid <= valid_in && in_range;
      if (valid_in) begin
        s1_x      <= x_in;
        s1_y      <= y_in;
        s1_colour <= palette_lookup(best_block_in);
        s1_miss   <= (best_block_in >= 4'(NUM_BLOCKS));
        s1_neg    <= best_t_in[31];
        s1_exp    <= best_t_in[30:23];
      end
    end
  end

`ifdef DEPTH_SHADE_EN
  logic signed [9:0] exp_d;

  always_comb begin
    exp_d = $signed({2'b00, s1_exp}) - 10'sd127 - $signed(10'(SHADE_BIAS));
    shift = 2'd0;
    if (exp_d > 10'sd3)       shift = 2'd3;
    else if (exp_d > 10'sd0)  shift = exp_d[1:0];
    bg = s1_neg || (s1_exp == 8'hFF) || s1_miss;
  end
`else
  logic unused_exp;
  assign unused_exp = &{1'b0, s1_exp};

  always_comb begin
    shift = 2'd0;
    bg    = s1_neg || s1_miss;
  end
`endif

  always_comb begin
    shaded = {s1_colour[11:8] >> shift, s1_colour[7:4] >> shift,
              s1_colour[3:0] >> shift};
    if (bg) shaded = BG_COLOUR;
    addr = {7'd0, s1_y} * 17'(H_RES) + {6'd0, s1_x};
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      s2_valid  <= 1'b0;
      s2_addr   <= '0;
      s2_colour <= BG_COLOUR;
    end else begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_addr   <= addr;
        s2_colour <= shaded;
      end
    end
  end

  result_fifo #(
    .WIDTH(29),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk_in),
    .rst   (rst_in),
    .push  (s2_valid),
    .din   ({s2_addr, s2_colour}),
    .pop   (accept),
    .dout  ({fb_addr, fb_data}),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign fb_we  = !fifo_empty;
  assign accept = fb_we && fb_ready;

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      frame_done <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      frame_done <= accept && (fb_addr == LAST_ADDR);
      if (s2_valid && fifo_full && !accept) overflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_hit_shade_writer.sv
// Self-checking bench for hit_shade_writer: table of single-pixel vectors
// followed by directed sequences for backpressure, frame end and reset.
module tb_hit_shade_writer;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic [10:0] x_in;
  logic [9:0]  y_in;
  logic [3:0]  best_block_in;
  logic [31:0] best_t_in;
  logic        valid_in;
  logic        fb_ready;
  logic [16:0] fb_addr;
  logic [11:0] fb_data;
  logic        fb_we;
  logic        frame_done;
  logic        overflow;

  int n_checks = 0;
  int n_fail   = 0;

`ifdef DEPTH_SHADE_EN
  localparam bit SHADE = 1'b1;
`else
  localparam bit SHADE = 1'b0;
`endif

  hit_shade_writer #(
    .H_RES(320),
    .V_RES(240),
    .FIFO_DEPTH(16),
    .SHADE_BIAS(0)
  ) dut (
    .clk_in        (clk_in),
    .rst_in        (rst_in),
    .x_in          (x_in),
    .y_in          (y_in),
    .best_block_in (best_block_in),
    .best_t_in     (best_t_in),
    .valid_in      (valid_in),
    .fb_ready      (fb_ready),
    .fb_addr       (fb_addr),
    .fb_data       (fb_data),
    .fb_we         (fb_we),
    .frame_done    (frame_done),
    .overflow      (overflow)
  );

  always #5 clk_in = ~clk_in;

  typedef struct {
    logic [10:0] x;
    logic [9:0]  y;
    logic [3:0]  blk;
    logic [31:0] t;
    bit          we;
    logic [16:0] addr;
    logic [11:0] data;
  } vec_t;

  vec_t vecs [11];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive_pixel(input logic [10:0] x, input logic [9:0] y,
                             input logic [3:0] blk, input logic [31:0] t);
    valid_in      = 1'b1;
    x_in          = x;
    y_in          = y;
    best_block_in = blk;
    best_t_in     = t;
  endtask

  initial begin
    vecs[0]  = '{11'd5,   10'd2,   4'd0,  32'h3F800000, 1'b1, 17'd645,   12'hF00};
    vecs[1]  = '{11'd0,   10'd0,   4'd0,  32'h41000000, 1'b1, 17'd0,     SHADE ? 12'h100 : 12'hF00};
    vecs[2]  = '{11'd10,  10'd1,   4'd15, 32'h3F800000, 1'b1, 17'd330,   12'h000};
    vecs[3]  = '{11'd3,   10'd3,   4'd1,  32'hBF800000, 1'b1, 17'd963,   12'h000};
    vecs[4]  = '{11'd320, 10'd0,   4'd0,  32'h3F800000, 1'b0, 17'd0,     12'h000};
    vecs[5]  = '{11'd0,   10'd240, 4'd0,  32'h3F800000, 1'b0, 17'd0,     12'h000};
    vecs[6]  = '{11'd319, 10'd0,   4'd1,  32'h40000000, 1'b1, 17'd319,   SHADE ? 12'h070 : 12'h0F0};
    vecs[7]  = '{11'd1,   10'd1,   4'd2,  32'h7F800000, 1'b1, 17'd321,   SHADE ? 12'h000 : 12'h00F};
    vecs[8]  = '{11'd2,   10'd0,   4'd12, 32'h3F800000, 1'b1, 17'd2,     12'h000};
    vecs[9]  = '{11'd7,   10'd100, 4'd3,  32'h3F000000, 1'b1, 17'd32007, 12'hFF0};
    vecs[10] = '{11'd0,   10'd1,   4'd6,  32'h44800000, 1'b1, 17'd320,   SHADE ? 12'h111 : 12'hFFF};

    rst_in = 1'b1;
    valid_in = 1'b0;
    fb_ready = 1'b1;
    x_in = '0;
    y_in = '0;
    best_block_in = '0;
    best_t_in = '0;

    @(negedge clk_in);
    chk("reset_we", {31'd0, fb_we}, 32'd0);
    chk("reset_addr", {15'd0, fb_addr}, 32'd0);
    chk("reset_data", {20'd0, fb_data}, 32'd0);
    chk("reset_done", {31'd0, frame_done}, 32'd0);
    chk("reset_ovf", {31'd0, overflow}, 32'd0);
    @(negedge clk_in);
    rst_in = 1'b0;
    @(negedge clk_in);

    // Single pixels: result must appear exactly three edges after the input.
    for (int i = 0; i < 11; i++) begin
      drive_pixel(vecs[i].x, vecs[i].y, vecs[i].blk, vecs[i].t);
      @(negedge clk_in);
      valid_in = 1'b0;
      @(negedge clk_in);
      chk($sformatf("vec%0d_early_we", i), {31'd0, fb_we}, 32'd0);
      @(negedge clk_in);
      chk($sformatf("vec%0d_we", i), {31'd0, fb_we}, {31'd0, vecs[i].we});
      if (vecs[i].we) begin
        chk($sformatf("vec%0d_addr", i), {15'd0, fb_addr}, {15'd0, vecs[i].addr});
        chk($sformatf("vec%0d_data", i), {20'd0, fb_data}, {20'd0, vecs[i].data});
      end
      chk($sformatf("vec%0d_done", i), {31'd0, frame_done}, 32'd0);
      @(negedge clk_in);
      chk($sformatf("vec%0d_drained", i), {31'd0, fb_we}, 32'd0);
    end

    // Backpressure: 17 pixels into a 16-deep FIFO with the port stalled.
    fb_ready = 1'b0;
    for (int i = 0; i < 17; i++) begin
      drive_pixel(11'(i), 10'd5, 4'(i % 12), 32'h3F800000);
      @(negedge clk_in);
    end
    valid_in = 1'b0;
    repeat (4) @(negedge clk_in);
    chk("bp_overflow", {31'd0, overflow}, 32'd1);
    chk("bp_we_held", {31'd0, fb_we}, 32'd1);
    fb_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      logic [11:0] pal [12];
      pal = '{12'hF00, 12'h0F0, 12'h00F, 12'hFF0, 12'h0FF, 12'hF0F,
              12'hFFF, 12'h888, 12'hF80, 12'h8F0, 12'h08F, 12'h444};
      chk($sformatf("bp_we_%0d", i), {31'd0, fb_we}, 32'd1);
      chk($sformatf("bp_addr_%0d", i), {15'd0, fb_addr}, 32'd1600 + 32'(i));
      chk($sformatf("bp_data_%0d", i), {20'd0, fb_data}, {20'd0, pal[i % 12]});
      @(negedge clk_in);
    end
    chk("bp_empty_after", {31'd0, fb_we}, 32'd0);
    chk("bp_overflow_sticky", {31'd0, overflow}, 32'd1);

    // Frame end, twice.
    for (int k = 0; k < 2; k++) begin
      drive_pixel(11'd319, 10'd239, 4'd0, 32'h3F800000);
      @(negedge clk_in);
      valid_in = 1'b0;
      repeat (2) @(negedge clk_in);
      chk($sformatf("fd%0d_we", k), {31'd0, fb_we}, 32'd1);
      chk($sformatf("fd%0d_addr", k), {15'd0, fb_addr}, 32'd76799);
      chk($sformatf("fd%0d_pre", k), {31'd0, frame_done}, 32'd0);
      @(negedge clk_in);
      chk($sformatf("fd%0d_pulse", k), {31'd0, frame_done}, 32'd1);
      @(negedge clk_in);
      chk($sformatf("fd%0d_end", k), {31'd0, frame_done}, 32'd0);
    end

    // Reset while frame_done is high, overflow set and 5 entries queued.
    fb_ready = 1'b0;
    drive_pixel(11'd319, 10'd239, 4'd0, 32'h3F800000);
    @(negedge clk_in);
    for (int i = 0; i < 5; i++) begin
      drive_pixel(11'(i), 10'd7, 4'd1, 32'h3F800000);
      @(negedge clk_in);
    end
    valid_in = 1'b0;
    repeat (3) @(negedge clk_in);
    chk("rst_pre_addr", {15'd0, fb_addr}, 32'd76799);
    fb_ready = 1'b1;
    @(negedge clk_in);
    fb_ready = 1'b0;
    chk("rst_pre_done", {31'd0, frame_done}, 32'd1);
    chk("rst_pre_ovf", {31'd0, overflow}, 32'd1);
    chk("rst_pre_we", {31'd0, fb_we}, 32'd1);
    chk("rst_pre_next", {15'd0, fb_addr}, 32'd2240);
    #2 rst_in = 1'b1;
    #1;
    chk("rst_async_we", {31'd0, fb_we}, 32'd0);
    chk("rst_async_ovf", {31'd0, overflow}, 32'd0);
    chk("rst_async_done", {31'd0, frame_done}, 32'd0);
    chk("rst_async_addr", {15'd0, fb_addr}, 32'd0);
    chk("rst_async_data", {20'd0, fb_data}, 32'd0);
    @(negedge clk_in);
    rst_in = 1'b0;
    fb_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk_in);
      chk($sformatf("post_rst_we_%0d", i), {31'd0, fb_we}, 32'd0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
